// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus bundle: imem read channel, decode-side output channel and the
// flush/redirect/stall controls.
//   slave  : the fetch buffer (drives imem_read/imem_address and out_*)
//   master : the environment (imem, execute-stage flush, decode stall)
interface fetch_buffer_if;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  modport slave (
    input  flush, redirect_pc, stall, imem_resp, imem_rdata,
    output imem_read, imem_address, out_valid, out_instr, out_pc
  );

  modport master (
    output flush, redirect_pc, stall, imem_resp, imem_rdata,
    input  imem_read, imem_address, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/fetch_buffer.sv
// LC-3b fetch stage. Issues one instruction read at a time to imem and queues
// {pc, instr} pairs in a DEPTH-entry FIFO feeding decode. A flush squashes the
// FIFO, redirects the fetch PC and marks any read in flight as stale.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - fetch_buffer_if.slave: flush/redirect_pc/stall in, imem read channel,
//          out_valid/out_instr/out_pc head-of-queue to decode
// Configuration:
//   FETCH_BUF_BYPASS_EN - when defined, a response arriving with the FIFO empty is
//   shown on out_* in the same cycle and consumed directly if decode is not stalled.
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic          clk,
  input logic          rst,
  fetch_buffer_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e          state_q, state_d;
  logic            imem_read_q, imem_read_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic [15:0]     req_pc_q, req_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     mem_pc_q    [DEPTH];
  logic [15:0]     mem_instr_q [DEPTH];

  logic fifo_empty, fifo_full;
  logic resp_ok, bypass_show, bypass_take, push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(DEPTH));

  // A response is only useful in WAIT without a same-cycle flush.
  assign resp_ok = (state_q == StWait) && bus.imem_resp && !bus.flush;

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass_show = resp_ok && fifo_empty;
  assign bypass_take = bypass_show && !bus.stall;
`else
  assign bypass_show = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push = resp_ok && !bypass_take;
  // A pop in a flush cycle is void: the whole queue is squashed anyway.
  assign pop  = !fifo_empty && !bus.stall && !bus.flush;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    unique case (state_q)
      StIdle: begin
        // Issue gate uses the current count; a same-cycle pop is not credited.
        if (!bus.flush && !fifo_full) begin
          req_pc_d = fetch_pc_q;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (bus.imem_resp) begin
          state_d    = StIdle;
          fetch_pc_d = fetch_pc_q + 16'd2;
        end else if (bus.flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // The read still in flight belongs to the squashed path.
        if (bus.imem_resp) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.flush) begin
      fetch_pc_d = bus.redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end

    imem_read_d = (state_d == StWait) || (state_d == StDrain);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      imem_read_q <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      imem_read_q <= imem_read_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: out_* is forced to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]    <= req_pc_q;
      mem_instr_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_pc    = 16'h0000;
    bus.out_instr = 16'h0000;
    if (!fifo_empty) begin
      bus.out_valid = 1'b1;
      bus.out_pc    = mem_pc_q[rd_ptr_q];
      bus.out_instr = mem_instr_q[rd_ptr_q];
    end else if (bypass_show) begin
      bus.out_valid = 1'b1;
      bus.out_pc    = req_pc_q;
      bus.out_instr = bus.imem_rdata;
    end
  end

  assign bus.imem_read    = imem_read_q;
  assign bus.imem_address = req_pc_q;

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
  localparam int unsigned DEPTH = 4;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_buffer_if bus ();

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a read-outstanding flag, a stale flag and a queue of {pc, instr}.
  logic        m_busy, m_stale;
  logic [15:0] m_fetch_pc, m_req_pc;
  logic [31:0] m_q[$];
  logic        exp_read, exp_valid;
  logic [15:0] exp_addr, exp_pc, exp_instr;

  // Memory responder controls.
  bit auto_mem, rand_data, rand_lat, spurious;
  int lat, wait_cnt;

  function automatic logic [15:0] data_of(input logic [15:0] a);
    return {a[7:0], ~a[15:8]};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_stale = 1'b0; m_fetch_pc = 16'h0000; m_req_pc = 16'h0000;
    m_q.delete(); wait_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if (auto_mem) bus.imem_resp = 1'b0;
    #2;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive the memory response, form expectations, move to the sampling point.
  task automatic settle();
    bit byp;
    if (auto_mem) begin
      bus.imem_resp = 1'b0;
      if (m_busy) begin
        if (wait_cnt >= lat) begin
          bus.imem_resp  = 1'b1;
          bus.imem_rdata = rand_data ? 16'($urandom) : data_of(m_req_pc);
        end else begin
          wait_cnt++;
        end
      end else if (spurious && $urandom_range(0, 7) == 0) begin
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'($urandom);
      end
    end
    exp_read = m_busy;
    exp_addr = m_req_pc;
    byp = BYPASS && m_busy && !m_stale && bus.imem_resp && !bus.flush && m_q.size() == 0;
    if (m_q.size() != 0) begin
      exp_valid = 1'b1; exp_pc = m_q[0][31:16]; exp_instr = m_q[0][15:0];
    end else if (byp) begin
      exp_valid = 1'b1; exp_pc = m_req_pc; exp_instr = bus.imem_rdata;
    end else begin
      exp_valid = 1'b0; exp_pc = 16'h0000; exp_instr = 16'h0000;
    end
    @(negedge clk);
  endtask

  // Clock edge, then advance the model with the inputs of the cycle just ended.
  task automatic advance();
    bit do_pop, do_push, start;
    @(posedge clk);
    do_pop = 1'b0; do_push = 1'b0; start = 1'b0;
    if (!rst) begin
      if (bus.flush) begin
        m_q.delete();
        m_fetch_pc = bus.redirect_pc;
        if (m_busy) begin
          if (bus.imem_resp) begin m_busy = 1'b0; m_stale = 1'b0; end
          else m_stale = 1'b1;
        end
      end else begin
        do_pop = (m_q.size() != 0) && !bus.stall;
        if (!m_busy) begin
          if (m_q.size() < DEPTH) begin m_busy = 1'b1; m_req_pc = m_fetch_pc; start = 1'b1; end
        end else if (m_stale) begin
          if (bus.imem_resp) begin m_busy = 1'b0; m_stale = 1'b0; end
        end else if (bus.imem_resp) begin
          do_push = !(BYPASS && m_q.size() == 0 && !bus.stall);
          m_fetch_pc = m_fetch_pc + 16'd2;
          m_busy = 1'b0;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back({m_req_pc, bus.imem_rdata});
      end
      if (start) begin
        wait_cnt = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    auto_mem = 1; rand_data = 0; rand_lat = 0; spurious = 0; lat = 6;
    bus.stall = 1'b0; bus.flush = 1'b0;
    do_reset();
    settle();
    checks++; if (bus.imem_read !== 1'b0) begin errors++; $display("FAIL reset_read got %0b want 0", bus.imem_read); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", bus.out_instr); end
    checks++; if (bus.out_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", bus.out_pc); end
    advance();
    settle();
    checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0000) begin errors++;
      $display("FAIL first_req got read=%0b addr=%h want read=1 addr=0000", bus.imem_read, bus.imem_address); end
    advance(); settle(); advance();
    // Asynchronous reset in the middle of a pending read.
    rst = 1'b1;
    #1;
    checks++; if (bus.imem_read !== 1'b0) begin errors++; $display("FAIL midwait_rst_read got %0b want 0", bus.imem_read); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midwait_rst_valid got %0b want 0", bus.out_valid); end
    model_reset();
    bus.imem_resp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    settle();
    checks++; if (bus.imem_read !== 1'b0) begin errors++; $display("FAIL post_rst_idle got %0b want 0", bus.imem_read); end
    advance();
    settle();
    checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0000) begin errors++;
      $display("FAIL post_rst_req got read=%0b addr=%h want read=1 addr=0000", bus.imem_read, bus.imem_address); end
    advance();
  endtask

  task automatic test_stream();
    logic [15:0] obs_pc[$], obs_instr[$];
    int req_cyc[$];
    logic [15:0] req_addr[$];
    logic prev_read;
    auto_mem = 1; rand_data = 0; rand_lat = 0; spurious = 0; lat = 0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    do_reset();
    prev_read = 1'b0;
    for (int c = 0; c < 14; c++) begin
      settle();
      if (bus.imem_read && !prev_read) begin req_cyc.push_back(c); req_addr.push_back(bus.imem_address); end
      prev_read = bus.imem_read;
      if (bus.out_valid && !bus.stall) begin obs_pc.push_back(bus.out_pc); obs_instr.push_back(bus.out_instr); end
      advance();
    end
    checks++; if (obs_pc.size() < 3 || req_cyc.size() < 4) begin errors++;
      $display("FAIL stream_count got pops=%0d reqs=%0d want >=3 >=4", obs_pc.size(), req_cyc.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs_pc[i] !== 16'(2 * i) || obs_instr[i] !== data_of(16'(2 * i))) begin errors++;
          $display("FAIL stream_entry%0d got pc=%h instr=%h want pc=%h instr=%h", i, obs_pc[i],
                   obs_instr[i], 16'(2 * i), data_of(16'(2 * i))); end
        checks++; if (req_cyc[i+1] - req_cyc[i] !== 2 || req_addr[i] !== 16'(2 * i)) begin errors++;
          $display("FAIL stream_req%0d got gap=%0d addr=%h want gap=2 addr=%h", i,
                   req_cyc[i+1] - req_cyc[i], req_addr[i], 16'(2 * i)); end
      end
    end
  endtask

  task automatic test_full();
    logic [15:0] obs_pc[$], obs_instr[$];
    logic [15:0] next_addr;
    bit got_req, read_seen;
    auto_mem = 1; rand_data = 0; rand_lat = 0; spurious = 0; lat = 0;
    bus.stall = 1'b1; bus.flush = 1'b0;
    do_reset();
    read_seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      settle();
      if (c >= 9 && bus.imem_read) read_seen = 1'b1;
      advance();
    end
    settle();
    checks++; if (read_seen || bus.imem_read !== 1'b0) begin errors++;
      $display("FAIL full_no_req got read=%0b seen=%0b want 0", bus.imem_read, read_seen); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000 || bus.out_instr !== data_of(16'h0000)) begin errors++;
      $display("FAIL full_head got v=%0b pc=%h instr=%h want v=1 pc=0000 instr=%h", bus.out_valid,
               bus.out_pc, bus.out_instr, data_of(16'h0000)); end
    advance();
    bus.stall = 1'b0;
    got_req = 1'b0; next_addr = 16'hFFFF;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (bus.out_valid) begin obs_pc.push_back(bus.out_pc); obs_instr.push_back(bus.out_instr); end
      if (bus.imem_read && !got_req) begin got_req = 1'b1; next_addr = bus.imem_address; end
      advance();
    end
    checks++; if (obs_pc.size() < 4) begin errors++; $display("FAIL full_drain_count got %0d want >=4", obs_pc.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (obs_pc[i] !== 16'(2 * i) || obs_instr[i] !== data_of(16'(2 * i))) begin errors++;
          $display("FAIL full_drain%0d got pc=%h instr=%h want pc=%h", i, obs_pc[i], obs_instr[i], 16'(2 * i)); end
      end
    end
    checks++; if (next_addr !== 16'h0008) begin errors++; $display("FAIL full_next_req got %h want 0008", next_addr); end
  endtask

  task automatic test_flush_wait();
    bit found, saw_dead, got_req;
    logic [15:0] first_addr;
    auto_mem = 1; rand_data = 0; rand_lat = 0; spurious = 0; lat = 0;
    bus.stall = 1'b1; bus.flush = 1'b0;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      settle(); advance();
      if (m_busy && m_req_pc == 16'h0006) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL flushw_setup got no read to 0006 want one"); end
    auto_mem = 0; bus.imem_resp = 1'b0;
    bus.flush = 1'b1; bus.redirect_pc = 16'h3000;
    settle();
    checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0006) begin errors++;
      $display("FAIL flushw_pending got read=%0b addr=%h want 1 0006", bus.imem_read, bus.imem_address); end
    advance();
    bus.flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0006 || bus.out_valid !== 1'b0) begin errors++;
        $display("FAIL flushw_drain%0d got read=%0b addr=%h v=%0b want 1 0006 0", k, bus.imem_read,
                 bus.imem_address, bus.out_valid); end
      advance();
    end
    bus.imem_resp = 1'b1; bus.imem_rdata = 16'hDEAD;
    settle(); advance();
    bus.imem_resp = 1'b0;
    auto_mem = 1; bus.stall = 1'b0;
    saw_dead = 1'b0; got_req = 1'b0; first_addr = 16'hFFFF;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (bus.out_valid && bus.out_instr == 16'hDEAD) saw_dead = 1'b1;
      if (bus.imem_read && !got_req) begin got_req = 1'b1; first_addr = bus.imem_address; end
      advance();
    end
    checks++; if (saw_dead !== 1'b0) begin errors++; $display("FAIL flushw_stale got DEAD on out_instr want never"); end
    checks++; if (first_addr !== 16'h3000) begin errors++; $display("FAIL flushw_redirect got %h want 3000", first_addr); end
  endtask

  task automatic test_flush_resp_pop();
    bit found;
    auto_mem = 1; rand_data = 0; rand_lat = 0; spurious = 0; lat = 0;
    bus.stall = 1'b1; bus.flush = 1'b0;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      settle(); advance();
      if (m_busy && m_req_pc == 16'h0004) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL frp_setup got no read to 0004 want one"); end
    bus.stall = 1'b0; bus.flush = 1'b1; bus.redirect_pc = 16'h0ABC;
    settle();
    checks++; if (bus.imem_read !== 1'b1 || bus.out_valid !== 1'b1 || bus.imem_resp !== 1'b1) begin errors++;
      $display("FAIL frp_collide got read=%0b v=%0b want 1 1", bus.imem_read, bus.out_valid); end
    advance();
    bus.flush = 1'b0;
    settle();
    checks++; if (bus.out_valid !== 1'b0 || bus.imem_read !== 1'b0) begin errors++;
      $display("FAIL frp_squash got v=%0b read=%0b want 0 0", bus.out_valid, bus.imem_read); end
    advance();
    // Response went back to IDLE; the redirected request follows one idle cycle later.
    settle();
    checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0ABC) begin errors++;
      $display("FAIL frp_redirect got read=%0b addr=%h want 1 0abc", bus.imem_read, bus.imem_address); end
    advance();
  endtask

  task automatic test_bypass();
    auto_mem = 0; rand_data = 0; rand_lat = 0; spurious = 0;
    bus.imem_resp = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    do_reset();
    bus.flush = 1'b1; bus.redirect_pc = 16'h0010;
    settle(); advance();
    bus.flush = 1'b0;
    settle(); advance();
    bus.imem_resp = 1'b1; bus.imem_rdata = 16'h1234;
    settle();
    checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0010) begin errors++;
      $display("FAIL byp_req got read=%0b addr=%h want 1 0010", bus.imem_read, bus.imem_address); end
`ifdef FETCH_BUF_BYPASS_EN
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'h1234 || bus.out_pc !== 16'h0010) begin errors++;
      $display("FAIL byp_same got v=%0b instr=%h pc=%h want 1 1234 0010", bus.out_valid, bus.out_instr, bus.out_pc); end
`else
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL byp_same got v=%0b want 0", bus.out_valid); end
`endif
    advance();
    bus.imem_resp = 1'b0;
    settle();
`ifdef FETCH_BUF_BYPASS_EN
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL byp_next got v=%0b want 0", bus.out_valid); end
`else
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'h1234 || bus.out_pc !== 16'h0010) begin errors++;
      $display("FAIL byp_next got v=%0b instr=%h pc=%h want 1 1234 0010", bus.out_valid, bus.out_instr, bus.out_pc); end
`endif
    advance();
  endtask

  task automatic test_random();
    logic [15:0] r;
    auto_mem = 1; rand_data = 1; rand_lat = 1; spurious = 1; lat = 0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bus.stall = ($urandom_range(0, 2) == 0);
      bus.flush = ($urandom_range(0, 13) == 0);
      r = 16'($urandom); r[0] = 1'b0;
      bus.redirect_pc = r;
      settle();
      checks++; if (bus.imem_read !== exp_read) begin errors++;
        $display("FAIL rnd_read c=%0d got %0b want %0b", c, bus.imem_read, exp_read); end
      if (exp_read) begin
        checks++; if (bus.imem_address !== exp_addr) begin errors++;
          $display("FAIL rnd_addr c=%0d got %h want %h", c, bus.imem_address, exp_addr); end
      end
      checks++; if (bus.out_valid !== exp_valid || bus.out_pc !== exp_pc || bus.out_instr !== exp_instr) begin errors++;
        $display("FAIL rnd_out c=%0d got v=%0b pc=%h instr=%h want v=%0b pc=%h instr=%h", c, bus.out_valid,
                 bus.out_pc, bus.out_instr, exp_valid, exp_pc, exp_instr); end
      advance();
    end
    bus.flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.redirect_pc = 16'h0000; bus.stall = 1'b0;
    bus.imem_resp = 1'b0; bus.imem_rdata = 16'h0000;
    auto_mem = 1; rand_data = 0; rand_lat = 0; spurious = 0; lat = 0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_full();
    test_flush_wait();
    test_flush_resp_pop();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
